// File: rtl/spi_row_receiver.sv
// spi_row_receiver: SPI mode-0 slave that receives one display row per frame.
// A frame is a row-index byte followed by ROW_BYTES pixel bytes; each pixel
// byte is written to a RAM port at {row, byte_index}. SPI pins are
// asynchronous and are synchronized into the clk domain before use.
module spi_row_receiver #(
    parameter int PIXEL_WIDTH      = 64,
    parameter int BYTES_PER_PIXEL  = 2,
    parameter int PIXEL_HALFHEIGHT = 16,
    localparam int RW        = $clog2(PIXEL_HALFHEIGHT),
    localparam int ROW_BYTES = PIXEL_WIDTH * BYTES_PER_PIXEL,
    localparam int BW        = $clog2(ROW_BYTES)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             spi_clk,
    input  logic             spi_cs,
    input  logic             spi_mosi,
    output logic             ram_we,
    output logic [RW+BW-1:0] ram_addr,
    output logic [7:0]       ram_data,
    output logic             row_done,
    output logic             busy,
    output logic             frame_error
);

    localparam logic [BW-1:0] LAST_IDX  = BW'(ROW_BYTES - 1);
    localparam logic [8:0]    ROW_LIMIT = 9'(PIXEL_HALFHEIGHT);

    typedef enum logic [2:0] {IDLE, GET_ROW, DATA, DONE, DRAIN} state_t;

    // Front end: synchronizers, edge detect, bit/byte assembly
    logic       sck_s1_q, sck_s2_q, sck_s3_q, sck_rise_q;
    logic       cs_s1_q, cs_s2_q, cs_s3_q;
    logic       mosi_s1_q, mosi_s2_q, mosi_s3_q;
    logic [1:0] warm_q;
    logic       armed_q, armed_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       got_bit_q, got_bit_d;
    logic       last_bit_q, last_bit_d;
    logic       byte_valid_q;
    logic       sck_rise_d;
    logic       cs_fall, cs_rise;

    // FSM and registered outputs
    state_t            state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [BW-1:0]     idx_q, idx_d;
    logic              full_q, full_d;
    logic              ram_we_q, ram_we_d;
    logic [RW+BW-1:0]  ram_addr_q, ram_addr_d;
    logic [7:0]        ram_data_q, ram_data_d;
    logic              row_done_q, row_done_d;
    logic              frame_error_q, frame_error_d;

    // CS edges. A fall only counts once CS has really been seen high since
    // reset, so a frame that was interrupted by reset is never resumed.
    assign cs_fall = armed_q & cs_s3_q & ~cs_s2_q;
    assign cs_rise = ~cs_s3_q & cs_s2_q;

    // Next-state for the bit shifter; MOSI is delayed one extra stage to stay
    // aligned with the registered SCK rise pulse.
    always_comb begin
        sck_rise_d = sck_s2_q & ~sck_s3_q;
        armed_d    = armed_q | (cs_s2_q & warm_q[1]);
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        got_bit_d  = got_bit_q;
        last_bit_d = 1'b0;
        if (cs_s2_q) begin
            bit_cnt_d = 3'd0;
            got_bit_d = 1'b0;
        end else if (sck_rise_q) begin
            shift_d    = {shift_q[6:0], mosi_s3_q};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            got_bit_d  = 1'b1;
            last_bit_d = (bit_cnt_q == 3'd7);
        end
    end

    // Front-end registers; CS synchronizer idles high (inactive) in reset
    always_ff @(posedge clk) begin
        if (!rstb) begin
            sck_s1_q     <= 1'b0;
            sck_s2_q     <= 1'b0;
            sck_s3_q     <= 1'b0;
            sck_rise_q   <= 1'b0;
            cs_s1_q      <= 1'b1;
            cs_s2_q      <= 1'b1;
            cs_s3_q      <= 1'b1;
            mosi_s1_q    <= 1'b0;
            mosi_s2_q    <= 1'b0;
            mosi_s3_q    <= 1'b0;
            warm_q       <= 2'b00;
            armed_q      <= 1'b0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            got_bit_q    <= 1'b0;
            last_bit_q   <= 1'b0;
            byte_valid_q <= 1'b0;
        end else begin
            sck_s1_q     <= spi_clk;
            sck_s2_q     <= sck_s1_q;
            sck_s3_q     <= sck_s2_q;
            sck_rise_q   <= sck_rise_d;
            cs_s1_q      <= spi_cs;
            cs_s2_q      <= cs_s1_q;
            cs_s3_q      <= cs_s2_q;
            mosi_s1_q    <= spi_mosi;
            mosi_s2_q    <= mosi_s1_q;
            mosi_s3_q    <= mosi_s2_q;
            warm_q       <= {warm_q[0], 1'b1};
            armed_q      <= armed_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            got_bit_q    <= got_bit_d;
            last_bit_q   <= last_bit_d;
            byte_valid_q <= last_bit_q;
        end
    end

    // Frame FSM next-state and output decode; CS rise has priority everywhere
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        idx_d         = idx_q;
        full_d        = full_q;
        ram_we_d      = 1'b0;
        ram_addr_d    = ram_addr_q;
        ram_data_d    = ram_data_q;
        row_done_d    = 1'b0;
        frame_error_d = 1'b0;
        case (state_q)
            IDLE: begin
                full_d = 1'b0;
                if (cs_fall) state_d = GET_ROW;
            end
            GET_ROW: begin
                if (cs_rise) begin
                    state_d       = IDLE;
                    frame_error_d = got_bit_q;
                end else if (byte_valid_q) begin
                    row_d = shift_q[RW-1:0];
                    idx_d = '0;
                    if ({1'b0, shift_q} < ROW_LIMIT) begin
                        state_d = DATA;
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = DRAIN;
                    end
                end
            end
            DATA: begin
                if (cs_rise) begin
                    state_d       = IDLE;
                    frame_error_d = 1'b1;
                end else if (byte_valid_q) begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = {row_q, idx_q};
                    ram_data_d = shift_q;
                    if (idx_q == LAST_IDX) state_d = DONE;
                    else                   idx_d   = idx_q + BW'(1);
                end
            end
            DONE: begin
                row_done_d = 1'b1;
                full_d     = 1'b1;
                state_d    = cs_rise ? IDLE : DRAIN;
            end
            DRAIN: begin
                if (cs_rise)                     state_d       = IDLE;
                else if (byte_valid_q && full_q) frame_error_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q       <= IDLE;
            row_q         <= '0;
            idx_q         <= '0;
            full_q        <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_data_q    <= 8'd0;
            row_done_q    <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            idx_q         <= idx_d;
            full_q        <= full_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_q    <= ram_data_d;
            row_done_q    <= row_done_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_data    = ram_data_q;
    assign row_done    = row_done_q;
    assign frame_error = frame_error_q;
    assign busy        = (state_q == GET_ROW) || (state_q == DATA) || (state_q == DONE);

endmodule

// File: tb/tb_spi_row_receiver.sv
// Bench for spi_row_receiver: drives SPI frames at SCK = clk/4 and checks
// every RAM write (address, data, latency) against a queue of expected writes.
module tb_spi_row_receiver;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        spi_clk = 1'b0;
    logic        spi_cs = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        ram_we;
    logic [10:0] ram_addr;
    logic [7:0]  ram_data;
    logic        row_done;
    logic        busy;
    logic        frame_error;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int we_cnt = 0;
    int rd_cnt = 0;
    int fe_cnt = 0;
    int we0, rd0, fe0;

    typedef struct {
        logic [10:0] addr;
        logic [7:0]  data;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    spi_row_receiver dut (
        .clk         (clk),
        .rstb        (rstb),
        .spi_clk     (spi_clk),
        .spi_cs      (spi_cs),
        .spi_mosi    (spi_mosi),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_data    (ram_data),
        .row_done    (row_done),
        .busy        (busy),
        .frame_error (frame_error)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every write must have been predicted, in order, on time
    always @(negedge clk) begin
        if (ram_we) begin
            we_cnt++;
            check("we_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("addr", 32'(ram_addr), 32'(mon_e.addr));
                check("data", 32'(ram_data), 32'(mon_e.data));
                check("latency", cyc, mon_e.cyc);
                $display("wr addr=0x%03h data=0x%02h cyc=%0d", ram_addr, ram_data, cyc);
            end
        end
        if (row_done) rd_cnt++;
        if (frame_error) fe_cnt++;
    end

    // One SPI byte, MSB first; the 8th rise is registered by the next posedge,
    // and the write must appear 5 edges later, i.e. cyc+6 at that negedge.
    task automatic send_byte(input logic [7:0] b, input bit expect_wr, input logic [10:0] addr);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            spi_clk  = 1'b0;
            spi_mosi = b[i];
            repeat (2) @(negedge clk);
            spi_clk = 1'b1;
            if (i == 0 && expect_wr) exp_q.push_back('{addr, b, cyc + 6});
            @(negedge clk);
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        spi_clk = 1'b0;
        spi_cs  = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        @(negedge clk);
        spi_clk = 1'b0;
        repeat (8) @(negedge clk);
        spi_cs = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_data(input logic [3:0] row, input int first, input int n, input bit expect_wr);
        for (int i = first; i < first + n; i++) begin
            send_byte(8'(i), expect_wr, {row, 7'(i)});
        end
    endtask

    task automatic snap();
        we0 = we_cnt;
        rd0 = rd_cnt;
        fe0 = fe_cnt;
    endtask

    task automatic expect_counts(input string tag, input int w, input int r, input int f);
        check({tag, "_writes"}, we_cnt - we0, w);
        check({tag, "_row_done"}, rd_cnt - rd0, r);
        check({tag, "_frame_error"}, fe_cnt - fe0, f);
        check({tag, "_pending"}, exp_q.size(), 0);
        $display("frame %s: writes=%0d row_done=%0d frame_error=%0d", tag,
                 we_cnt - we0, rd_cnt - rd0, fe_cnt - fe0);
    endtask

    initial begin
        // Reset state
        repeat (4) @(negedge clk);
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_ram_data", 32'(ram_data), 0);
        check("rst_row_done", 32'(row_done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_error", 32'(frame_error), 0);
        rstb = 1'b1;
        repeat (6) @(negedge clk);
        check("idle_busy", 32'(busy), 0);

        // Full row to row 5
        snap();
        cs_low();
        send_byte(8'h05, 1'b0, 11'd0);
        repeat (6) @(negedge clk);
        check("data_busy", 32'(busy), 1);
        send_data(4'h5, 0, 128, 1'b1);
        cs_high();
        expect_counts("full_row", 128, 1, 0);
        check("hold_addr", 32'(ram_addr), 32'h2FF);
        check("hold_data", 32'(ram_data), 32'h7F);
        check("after_busy", 32'(busy), 0);

        // Row index out of range
        snap();
        cs_low();
        send_byte(8'h10, 1'b0, 11'd0);
        repeat (8) @(negedge clk);
        check("bad_row_busy", 32'(busy), 0);
        cs_high();
        expect_counts("bad_row", 0, 0, 1);

        // Truncated frame
        snap();
        cs_low();
        send_byte(8'h03, 1'b0, 11'd0);
        send_data(4'h3, 0, 10, 1'b1);
        cs_high();
        expect_counts("truncated", 10, 0, 1);

        // Overrun: two extra bytes after a complete row
        snap();
        cs_low();
        send_byte(8'h0F, 1'b0, 11'd0);
        send_data(4'hF, 0, 128, 1'b1);
        send_byte(8'hAA, 1'b0, 11'd0);
        send_byte(8'h55, 1'b0, 11'd0);
        cs_high();
        expect_counts("overrun", 128, 1, 2);

        // Reset in the middle of a row with CS held low
        snap();
        cs_low();
        send_byte(8'h02, 1'b0, 11'd0);
        send_data(4'h2, 0, 40, 1'b1);
        repeat (10) @(negedge clk);
        rstb = 1'b0;
        @(negedge clk);
        check("midrst_ram_we", 32'(ram_we), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_ram_addr", 32'(ram_addr), 0);
        @(negedge clk);
        rstb = 1'b1;
        send_data(4'h2, 40, 50, 1'b0);
        check("post_rst_busy", 32'(busy), 0);
        cs_high();
        expect_counts("reset_mid", 40, 0, 0);

        // Next frame after the aborted one completes normally
        snap();
        cs_low();
        send_byte(8'h07, 1'b0, 11'd0);
        send_data(4'h7, 0, 128, 1'b1);
        cs_high();
        expect_counts("after_reset", 128, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
